// File: rtl/delay_pkg.sv
// Shared types and helpers for the programmable tap delay line.
// Arithmetic is done in a wide fixed type; callers cast down to their own widths.
package delay_pkg;

  localparam int unsigned DLY_BITS = 16;

  typedef logic [DLY_BITS-1:0] dly_t;

  // Effective delay: 0 behaves as 1, anything past the buffer depth saturates.
  function automatic dly_t clamp_delay(input dly_t sel, input dly_t max_d);
    if (sel == '0) return dly_t'(1);
    if (sel > max_d) return max_d;
    return sel;
  endfunction

  // (ptr - n) mod max_d for ptr < max_d and n < max_d, without a divider.
  function automatic dly_t ptr_dec(input dly_t ptr, input dly_t n, input dly_t max_d);
    return (ptr >= n) ? (ptr - n) : (ptr + max_d - n);
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Circular-buffer storage: one synchronous write port, one asynchronous read port.
module delay_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; history is only trusted once the fill counter
  // says enough pushes have landed, so clearing it would just cost hardware.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tap_delay.sv
// Runtime-selectable delay line: samples enter a circular buffer and the output
// is read from a tap D-1 pushes behind the write pointer, with a history-valid flag.
module tap_delay
  import delay_pkg::*;
#(
  parameter int MAX_DELAY = 16,
  parameter int WIDTH     = 2,
  localparam int DW       = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  input  logic [DW-1:0]    delay_sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int AW = $clog2(MAX_DELAY);

  logic [DW-1:0]    d_q, d_next;
  logic [DW-1:0]    fill, fill_next;
  logic [AW-1:0]    wptr, wptr_next, rd_idx;
  logic [WIDTH-1:0] rd_data, out_next;
  logic             delay_change;

  delay_ram #(
    .DEPTH(MAX_DELAY),
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (en),
    .waddr(wptr),
    .wdata(in),
    .raddr(rd_idx),
    .rdata(rd_data)
  );

  // NOTE: every always_comb output is assigned on every path (fill_next via a
  // full if/else chain) so no latch can be inferred.
  always_comb begin
    d_next       = DW'(clamp_delay(dly_t'(delay_sel), dly_t'(MAX_DELAY)));
    delay_change = (d_next != d_q);

    if (delay_change)                            fill_next = en ? DW'(1) : '0;
    else if (en && (fill != DW'(MAX_DELAY)))     fill_next = fill + DW'(1);
    else                                         fill_next = fill;

    wptr_next = (wptr == AW'(MAX_DELAY - 1)) ? '0 : wptr + AW'(1);

    // The read sees the buffer before this edge's write, so D=1 bypasses to in.
    rd_idx   = AW'(ptr_dec(dly_t'(wptr), dly_t'(d_next) - dly_t'(1), dly_t'(MAX_DELAY)));
    out_next = (d_next == DW'(1)) ? in : rd_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values computed above regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q       <= DW'(1);
      fill      <= '0;
      wptr      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      d_q       <= d_next;
      fill      <= fill_next;
      out_valid <= (fill_next >= d_next);
      if (en) begin
        wptr <= wptr_next;
        out  <= out_next;
      end
    end
  end

endmodule

// File: tb/tb_tap_delay.sv
// Directed bench for tap_delay (MAX_DELAY=8, WIDTH=4) with hand-computed expectations.
module tb_tap_delay;

  localparam int MAX_DELAY = 8;
  localparam int WIDTH     = 4;
  localparam int DW        = $clog2(MAX_DELAY + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [WIDTH-1:0] in_d = '0;
  logic [DW-1:0]    delay_sel = DW'(1);
  logic [WIDTH-1:0] out;
  logic             out_valid;

  int checks = 0;
  int failures = 0;

  tap_delay #(.MAX_DELAY(MAX_DELAY), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in       (in_d),
    .delay_sel(delay_sel),
    .out      (out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive on the falling edge, let one rising edge happen, sample 1ns later.
  task automatic step(input logic e, input logic [WIDTH-1:0] d, input logic [DW-1:0] s);
    @(negedge clk);
    en = e;
    in_d = d;
    delay_sel = s;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear with no clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    checks++;
    if (out !== '0) begin
      failures++;
      $display("FAIL %s_reset_out: got %h expected 0", tag, out);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_reset_valid: got %b expected 0", tag, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset("initial");
  endtask

  // D=3: push 3,2,1,0,1 -> out 3,2,1 on e2..e4, valid rises at e2.
  task automatic test_basic_d3();
    logic [WIDTH-1:0] vin [5] = '{4'h3, 4'h2, 4'h1, 4'h0, 4'h1};
    logic [WIDTH-1:0] vout[5] = '{4'h0, 4'h0, 4'h3, 4'h2, 4'h1};
    logic             vval[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset("basic");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, vin[i], DW'(3));
      checks++;
      if (out_valid !== vval[i]) begin
        failures++;
        $display("FAIL basic_valid e%0d: got %b expected %b", i, out_valid, vval[i]);
      end
      if (i >= 2) begin
        checks++;
        if (out !== vout[i]) begin
          failures++;
          $display("FAIL basic_out e%0d: got %h expected %h", i, out, vout[i]);
        end
      end
    end
  endtask

  // D=1: out mirrors the sample pushed on the same edge, valid from the first push.
  task automatic test_d1();
    logic [WIDTH-1:0] vin[4] = '{4'h5, 4'h9, 4'hA, 4'h3};
    do_reset("d1");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vin[i], DW'(1));
      checks++;
      if (out !== vin[i] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL d1 e%0d: got out=%h valid=%b expected out=%h valid=1",
                 i, out, out_valid, vin[i]);
      end
    end
  endtask

  // D=MAX: ramp 0..15 wraps the write pointer twice; out = k-7 from push 7.
  task automatic test_max_wrap();
    do_reset("wrap");
    for (int k = 0; k < 16; k++) begin
      step(1'b1, WIDTH'(k), DW'(8));
      checks++;
      if (out_valid !== (k >= 7)) begin
        failures++;
        $display("FAIL wrap_valid k%0d: got %b expected %b", k, out_valid, (k >= 7));
      end
      if (k >= 7) begin
        checks++;
        if (out !== WIDTH'(k - 7)) begin
          failures++;
          $display("FAIL wrap_out k%0d: got %h expected %h", k, out, WIDTH'(k - 7));
        end
      end
    end
  endtask

  // D=3 stream, switch to 5 at push 10: valid drops at 10, returns at 14, out = k-4.
  task automatic test_delay_change();
    logic [DW-1:0] sel;
    logic          exp_v;
    logic [WIDTH-1:0] exp_o;
    do_reset("chg");
    for (int k = 0; k < 16; k++) begin
      sel = (k < 10) ? DW'(3) : DW'(5);
      step(1'b1, WIDTH'(k), sel);
      exp_v = (k < 10) ? (k >= 2) : (k >= 14);
      exp_o = (k < 10) ? WIDTH'(k - 2) : WIDTH'(k - 4);
      checks++;
      if (out_valid !== exp_v) begin
        failures++;
        $display("FAIL chg_valid k%0d: got %b expected %b", k, out_valid, exp_v);
      end
      if (k >= 2) begin
        checks++;
        if (out !== exp_o) begin
          failures++;
          $display("FAIL chg_out k%0d: got %h expected %h", k, out, exp_o);
        end
      end
    end
  endtask

  // D=3 with en 1,0,0,1,1: valid counts pushes; then idle edges hold out/valid.
  task automatic test_idle();
    logic             ven [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [WIDTH-1:0] vin [7] = '{4'h1, 4'hF, 4'hE, 4'h2, 4'h3, 4'hD, 4'hC};
    logic             vval[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset("idle");
    for (int i = 0; i < 7; i++) begin
      step(ven[i], vin[i], DW'(3));
      checks++;
      if (out_valid !== vval[i]) begin
        failures++;
        $display("FAIL idle_valid e%0d: got %b expected %b", i, out_valid, vval[i]);
      end
      if (i >= 4) begin
        checks++;
        if (out !== 4'h1) begin
          failures++;
          $display("FAIL idle_out e%0d: got %h expected 1", i, out);
        end
      end
    end
    step(1'b1, 4'h4, DW'(3));
    checks++;
    if (out !== 4'h2 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL idle_resume: got out=%h valid=%b expected out=2 valid=1", out, out_valid);
    end
  endtask

  // Mid-stream reset, then delay_sel=0 acts as D=1 and delay_sel=12 as D=8.
  task automatic test_reset_clamp();
    do_reset("mid");
    for (int k = 0; k < 4; k++) step(1'b1, WIDTH'(k + 6), DW'(2));
    do_reset("midstream");
    step(1'b1, 4'h7, DW'(0));
    checks++;
    if (out !== 4'h7 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL clamp_low: got out=%h valid=%b expected out=7 valid=1", out, out_valid);
    end
    do_reset("clamp_hi");
    for (int k = 0; k < 10; k++) begin
      step(1'b1, WIDTH'(k + 3), DW'(12));
      checks++;
      if (out_valid !== (k >= 7)) begin
        failures++;
        $display("FAIL clamp_high_valid k%0d: got %b expected %b", k, out_valid, (k >= 7));
      end
      if (k >= 7) begin
        checks++;
        if (out !== WIDTH'(k - 4)) begin
          failures++;
          $display("FAIL clamp_high_out k%0d: got %h expected %h", k, out, WIDTH'(k - 4));
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_d3();
    test_d1();
    test_max_wrap();
    test_delay_change();
    test_idle();
    test_reset_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
